// File: rtl/bpu.sv
// Branch prediction unit: direct-mapped BTB with 2-bit direction counters plus a return address stack.
// Latency 0 for lookup, tables trained one edge after upd_valid; no backpressure (fetch holds if_pc on stall).
module bpu #(
  parameter int XLEN        = 64,
  parameter int BTB_ENTRIES = 16,
  parameter int RAS_DEPTH   = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  input  logic [1:0]      upd_kind,
  output logic            ras_empty
);

  localparam int IDX  = $clog2(BTB_ENTRIES);
  localparam int TAGW = XLEN - IDX - 2;
  localparam int SPW  = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CW   = $clog2(RAS_DEPTH + 1);

  localparam logic [1:0]     K_COND  = 2'b00;
  localparam logic [1:0]     K_CALL  = 2'b10;
  localparam logic [1:0]     K_RET   = 2'b11;
  localparam logic [SPW-1:0] SP_MAX  = SPW'(RAS_DEPTH - 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(RAS_DEPTH);

  typedef struct packed {
    logic            valid;
    logic [TAGW-1:0] tag;
    logic [XLEN-1:0] target;
    logic [1:0]      kind;
    logic [1:0]      ctr;
  } btb_entry_t;

  btb_entry_t      btb [BTB_ENTRIES];
  logic [XLEN-1:0] ras [RAS_DEPTH];
  logic [SPW-1:0]  sp;
  logic [CW-1:0]   count;

  logic [SPW-1:0]  sp_inc;
  logic [SPW-1:0]  sp_dec;
  logic [XLEN-1:0] ras_top;

  assign sp_inc  = (sp == SP_MAX) ? '0 : sp + SPW'(1);
  assign sp_dec  = (sp == '0) ? SP_MAX : sp - SPW'(1);
  assign ras_top = ras[sp_dec];
  assign ras_empty = (count == '0);

  // Two-bit PC offset is never part of index or tag.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc[1:0], upd_pc[1:0]};

  // ---------------- lookup ----------------
  logic [IDX-1:0]  l_idx;
  logic [TAGW-1:0] l_tag;
  btb_entry_t      l_ent;
  logic            l_hit;

  assign l_idx = if_pc[IDX+1:2];
  assign l_tag = if_pc[XLEN-1:IDX+2];
  assign l_ent = btb[l_idx];
  assign l_hit = l_ent.valid && (l_ent.tag == l_tag);

  always_comb begin
    pred_taken  = l_hit && ((l_ent.kind != K_COND) || l_ent.ctr[1]);
    pred_target = if_pc + XLEN'(4);
    if (pred_taken && (l_ent.kind == K_RET) && !ras_empty) begin
      pred_target = ras_top;
    end else if (pred_taken) begin
      pred_target = l_ent.target;
    end
  end

  // ---------------- training ----------------
  logic [IDX-1:0]  u_idx;
  logic [TAGW-1:0] u_tag;
  btb_entry_t      u_ent;
  logic            u_hit;
  logic            u_wr;
  btb_entry_t      u_new;
  logic [1:0]      u_ctr;

  assign u_idx = upd_pc[IDX+1:2];
  assign u_tag = upd_pc[XLEN-1:IDX+2];
  assign u_ent = btb[u_idx];
  assign u_hit = u_ent.valid && (u_ent.tag == u_tag);

  always_comb begin
    u_ctr = 2'b11;
    if (upd_kind == K_COND) begin
      if (upd_taken) u_ctr = (u_ent.ctr == 2'b11) ? 2'b11 : u_ent.ctr + 2'd1;
      else           u_ctr = (u_ent.ctr == 2'b00) ? 2'b00 : u_ent.ctr - 2'd1;
    end
  end

  always_comb begin
    u_wr  = 1'b0;
    u_new = u_ent;
    if (upd_valid) begin
      if (u_hit) begin
        u_wr      = 1'b1;
        u_new.ctr = u_ctr;
        if (upd_taken) begin
          u_new.target = upd_target;
          u_new.kind   = upd_kind;
        end
      end else if (upd_taken) begin
        u_wr         = 1'b1;
        u_new.valid  = 1'b1;
        u_new.tag    = u_tag;
        u_new.target = upd_target;
        u_new.kind   = upd_kind;
        u_new.ctr    = (upd_kind == K_COND) ? 2'b10 : 2'b11;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BTB_ENTRIES; i++) btb[i] <= '0;
    end else if (u_wr) begin
      btb[u_idx] <= u_new;
    end
  end

  // Stack pointer and occupancy; a push when full overwrites the oldest slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp    <= '0;
      count <= '0;
    end else if (upd_valid) begin
      if (upd_kind == K_CALL) begin
        sp    <= sp_inc;
        count <= (count == CNT_MAX) ? count : count + CW'(1);
      end else if ((upd_kind == K_RET) && (count != '0)) begin
        sp    <= sp_dec;
        count <= count - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && upd_valid && (upd_kind == K_CALL)) begin
      ras[sp] <= upd_pc + XLEN'(4);
    end
  end

endmodule

// File: tb/tb_bpu.sv
// Self-checking bench for bpu: expected predictions queued at drive time, compared on the falling edge.
module tb_bpu;

  localparam logic [63:0] B = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] if_pc;
  logic        pred_taken;
  logic [63:0] pred_target;
  logic        upd_valid;
  logic [63:0] upd_pc;
  logic        upd_taken;
  logic [63:0] upd_target;
  logic [1:0]  upd_kind;
  logic        ras_empty;

  bpu #(.XLEN(64), .BTB_ENTRIES(16), .RAS_DEPTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .if_pc       (if_pc),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .upd_valid   (upd_valid),
    .upd_pc      (upd_pc),
    .upd_taken   (upd_taken),
    .upd_target  (upd_target),
    .upd_kind    (upd_kind),
    .ras_empty   (ras_empty)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        tk;
    logic [63:0] tgt;
    logic        re;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    n_checks = 0;
  int    n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  exp_t  cur_e;
  string cur_t;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      cur_e = exp_q.pop_front();
      cur_t = tag_q.pop_front();
      chk({cur_t, ".taken"},  {63'd0, pred_taken}, {63'd0, cur_e.tk});
      chk({cur_t, ".target"}, pred_target,         cur_e.tgt);
      chk({cur_t, ".ras_empty"}, {63'd0, ras_empty}, {63'd0, cur_e.re});
    end
  end

  task automatic expect_pred(input string tag, input logic tk, input logic [63:0] tgt, input logic re);
    exp_t e;
    e.tk  = tk;
    e.tgt = tgt;
    e.re  = re;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // All drive tasks start and end one time unit after a rising edge.
  task automatic look(input string tag, input logic [63:0] pc, input logic tk,
                      input logic [63:0] tgt, input logic re);
    if_pc = pc;
    expect_pred(tag, tk, tgt, re);
    @(posedge clk); #1;
  endtask

  task automatic upd(input logic [63:0] pc, input logic [1:0] k, input logic t, input logic [63:0] tg);
    upd_valid  = 1'b1;
    upd_pc     = pc;
    upd_kind   = k;
    upd_taken  = t;
    upd_target = tg;
    @(posedge clk); #1;
    upd_valid  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; if_pc = '0; upd_valid = 1'b0; upd_pc = '0;
    upd_taken = 1'b0; upd_target = '0; upd_kind = 2'b00;
    @(posedge clk); #1;
    look("reset", B, 1'b0, B + 64'h4, 1'b1);
    rst_n = 1'b1;
    look("post_reset", B, 1'b0, B + 64'h4, 1'b1);

    // Conditional branch allocation and index aliasing
    upd(B + 64'h10, 2'b00, 1'b1, B + 64'h100);
    look("alloc_hit", B + 64'h10, 1'b1, B + 64'h100, 1'b1);
    look("alias_miss", B + 64'h50, 1'b0, B + 64'h54, 1'b1);

    // Counter saturation
    repeat (3) upd(B + 64'h10, 2'b00, 1'b1, B + 64'h100);
    upd(B + 64'h10, 2'b00, 1'b0, B + 64'h100);
    look("ctr_10", B + 64'h10, 1'b1, B + 64'h100, 1'b1);
    upd(B + 64'h10, 2'b00, 1'b0, B + 64'h100);
    look("ctr_01", B + 64'h10, 1'b0, B + 64'h14, 1'b1);
    repeat (2) upd(B + 64'h10, 2'b00, 1'b0, B + 64'h100);
    look("ctr_00", B + 64'h10, 1'b0, B + 64'h14, 1'b1);
    upd(B + 64'h10, 2'b00, 1'b1, B + 64'h100);
    look("ctr_00_to_01", B + 64'h10, 1'b0, B + 64'h14, 1'b1);
    upd(B + 64'h10, 2'b00, 1'b1, B + 64'h100);
    look("ctr_01_to_10", B + 64'h10, 1'b1, B + 64'h100, 1'b1);

    // Call / return
    upd(B + 64'h20, 2'b10, 1'b1, B + 64'h200);
    look("call_hit", B + 64'h20, 1'b1, B + 64'h200, 1'b0);
    upd(B + 64'h204, 2'b11, 1'b1, B + 64'h24);
    look("ret_empty_btb", B + 64'h204, 1'b1, B + 64'h24, 1'b1);
    upd(B + 64'h30, 2'b10, 1'b1, B + 64'h200);
    look("ret_from_ras", B + 64'h204, 1'b1, B + 64'h34, 1'b0);

    // Overflow: five more pushes A..E, the stack keeps only the newest four
    for (int i = 0; i < 5; i++) upd(B + 64'h1000 + 64'(i * 16), 2'b10, 1'b1, B + 64'h200);
    look("ras_top_E", B + 64'h204, 1'b1, B + 64'h1044, 1'b0);
    repeat (3) upd(B + 64'h204, 2'b11, 1'b1, B + 64'h24);
    look("ras_top_B", B + 64'h204, 1'b1, B + 64'h1014, 1'b0);
    upd(B + 64'h204, 2'b11, 1'b1, B + 64'h24);
    look("ras_drained", B + 64'h204, 1'b1, B + 64'h24, 1'b1);
    upd(B + 64'h204, 2'b11, 1'b1, B + 64'h24);
    look("ras_underflow", B + 64'h204, 1'b1, B + 64'h24, 1'b1);
    upd(B + 64'h1000, 2'b10, 1'b1, B + 64'h200);
    look("ras_push_after_underflow", B + 64'h204, 1'b1, B + 64'h1004, 1'b0);

    // Same-cycle lookup and allocate of the same PC
    if_pc      = B + 64'h400;
    expect_pred("hazard_same_cycle", 1'b0, B + 64'h404, 1'b0);
    upd(B + 64'h400, 2'b00, 1'b1, B + 64'h500);
    look("hazard_next_cycle", B + 64'h400, 1'b1, B + 64'h500, 1'b0);

    // Asynchronous reset in the middle of an update
    if_pc      = B + 64'h400;
    upd_valid  = 1'b1;
    upd_pc     = B + 64'h600;
    upd_kind   = 2'b01;
    upd_taken  = 1'b1;
    upd_target = B + 64'h700;
    #1;
    chk("pre_reset.taken", {63'd0, pred_taken}, 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset.taken", {63'd0, pred_taken}, 64'd0);
    chk("async_reset.target", pred_target, B + 64'h404);
    chk("async_reset.ras_empty", {63'd0, ras_empty}, 64'd1);
    @(posedge clk); #1;
    upd_valid = 1'b0;
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    look("reset_discard_upd", B + 64'h600, 1'b0, B + 64'h604, 1'b1);
    look("reset_clears_btb", B + 64'h400, 1'b0, B + 64'h404, 1'b1);

    repeat (2) @(posedge clk);
    if (exp_q.size() != 0) chk("scoreboard_drain", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/bpu.md
# bpu

Branch prediction unit for the IF stage. It looks up the fetch PC in a direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters. Return targets come from a return address stack (RAS). It predicts the next fetch PC in the same cycle. Resolved control-flow outcomes from the branch/jump resolution stage train the tables non-speculatively, and the resolution stage remains the authority on mispredict redirects.

## Interface
- XLEN, 64, address/data width
- BTB_ENTRIES, 16, BTB entry count; power of 2, >= 2; IDX = log2(BTB_ENTRIES)
- RAS_DEPTH, 4, return stack entries; >= 1
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- if_pc  in  XLEN  current fetch PC (bits [1:0] ignored)
- pred_taken  out  1  predicted redirect for if_pc
- pred_target  out  XLEN  predicted next PC
- upd_valid  in  1  one resolved control-flow instruction this cycle
- upd_pc  in  XLEN  PC of the resolved instruction
- upd_taken  in  1  actual outcome; must be 1 for kinds 01/10/11
- upd_target  in  XLEN  actual taken target
- upd_kind  in  2  00 cond branch, 01 direct jump (jal, rd not link), 10 call (jal/jalr with rd=x1/x5), 11 return (jalr rs1=x1/x5, rd=x0)
- ras_empty  out  1  RAS count == 0 (debug/perf)

## Operation
- Index = pc[IDX+1:2]; tag = pc[XLEN-1:IDX+2].
- Entry fields: valid, tag, target[XLEN], kind[2], ctr[2].
- Lookup (combinational from registered state):
  - hit = valid & tag match.
  - pred_taken = hit & (kind != 00 | ctr[1]).
  - pred_target selection:
    - If pred_taken and kind == 11 and RAS is not empty: RAS top.
    - Else if pred_taken: entry target.
    - Else: if_pc + 4 (XLEN wrap-around).
- Update on upd_valid (registered at clk edge):
  - Hit at upd_pc:
    - Kind 00: ctr increments on taken, decrements on not-taken, saturating at 00/11.
    - Target and kind are rewritten when upd_taken.
    - Kinds != 00: ctr is forced to 11.
  - Miss and upd_taken: allocate (overwrite). valid=1, tag, target, kind. ctr = 10 for kind 00, else 11.
  - Miss and not taken: no write.
- RAS (non-speculative, driven by resolved updates only):
  - Kind 10 pushes upd_pc + 4. sp = (sp+1) mod RAS_DEPTH; count saturates at RAS_DEPTH. A push when full silently overwrites the oldest entry.
  - Kind 11 pops. sp = (sp-1) mod RAS_DEPTH; count decrements. A pop when empty is ignored.
  - Top = stack[sp-1 mod RAS_DEPTH].

## Timing
- Prediction latency 0: pred_* are valid in the same cycle as if_pc.
- Update is visible to lookups from the cycle after upd_valid.
- Lookup and update in the same cycle, same index: the lookup sees the pre-update contents.
- Push/pop and the RAS-top read in the same cycle: the read uses the pre-update top.
- Reset (asynchronous, rst_n=0):
  - All valid = 0, ctr = 00, sp = 0, count = 0.
  - Hence pred_taken = 0, pred_target = if_pc + 4, ras_empty = 1.
- Reset asserted mid-update: the update is discarded. Table contents are unspecified except valid = 0.
- No stall input. Fetch holds if_pc steady while stalled; the outputs follow.

## Test plan
- Reset, if_pc=0x8000_0000 -> pred_taken=0, pred_target=0x8000_0004, ras_empty=1.
- Cond-branch aliasing: BTB_ENTRIES=16.
  - Update pc=0x8000_0010 kind00, taken, target 0x8000_0100 -> next-cycle lookup of 0x8000_0010 gives taken, 0x8000_0100.
  - Lookup of 0x8000_0050 (same index, different tag) -> not taken, 0x8000_0054.
- Counter saturation on pc=0x8000_0010:
  - Three taken updates, then one not-taken -> lookup still taken (ctr 10).
  - Second not-taken -> not taken (ctr 01).
  - Two more not-taken -> ctr stays 00.
  - One taken -> still not taken (ctr 01).
- Call/return:
  - Call at 0x8000_0020 (target 0x8000_0200) trains the BTB and pushes 0x8000_0024.
  - Return at 0x8000_0204, trained with upd_target 0x8000_0024 (pops the RAS).
  - Second call at 0x8000_0030 (target 0x8000_0200) pushes 0x8000_0034.
  - Lookup 0x8000_0204 -> taken, 0x8000_0034 (RAS top, not the BTB target).
- RAS overflow/underflow, RAS_DEPTH=4:
  - 5 pushes (A..E) then lookup of a trained return -> E.
  - 4 pops -> ras_empty=1.
  - 5th pop -> no change, ras_empty stays 1; the return lookup falls back to the BTB target.
- Same-cycle hazard: upd_valid allocating pc X while if_pc=X -> that cycle not taken, X+4; the next cycle is taken. Asynchronous reset pulse mid-update -> all outputs revert to reset values immediately.
